// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// MMIO offsets count down from the top of the word address space.
package dm_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } dm_state_e;

    localparam int OFF_CYC_LO = 4;
    localparam int OFF_CYC_HI = 3;
    localparam int OFF_STCNT  = 2;
    localparam int OFF_TOHOST = 1;

    localparam logic [3:0] WEB_NONE = 4'hF;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  web
    );
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (!web[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dm_sram_responder_if.sv
// CPU data-memory port: zero-wait-state read and byte-masked write.
// The CPU side is the master, the responder is the slave.
interface dm_sram_responder_if #(
    parameter int AW = 14
);
    logic          DM_OE;
    logic [AW-1:0] DM_A;
    logic [3:0]    DM_WEB;
    logic [31:0]   DM_DI;
    logic [31:0]   DM_DO;

    modport master (
        output DM_OE, DM_A, DM_WEB, DM_DI,
        input  DM_DO
    );

    modport slave (
        input  DM_OE, DM_A, DM_WEB, DM_DI,
        output DM_DO
    );
endinterface

// File: rtl/dm_mmio_regs.sv
// Register window in the top four words: cycle counter with hi shadow,
// store counter and tohost. Only instantiated when DM_MMIO_EN is defined.
module dm_mmio_regs
    import dm_pkg::*;
#(
    parameter int DM_DEPTH = 16384
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ready_i,
    input  logic                        oe_i,
    input  logic [$clog2(DM_DEPTH)-1:0] addr_i,
    input  logic [3:0]                  web_i,
    input  logic [31:0]                 di_i,
    input  logic                        ram_we_i,
    output logic                        hit_o,
    output logic [31:0]                 rdata_o,
    output logic                        done_o,
    output logic [31:0]                 done_code_o
);
    localparam int AW = $clog2(DM_DEPTH);
    localparam logic [AW-1:0] A_LO = AW'(DM_DEPTH - OFF_CYC_LO);
    localparam logic [AW-1:0] A_HI = AW'(DM_DEPTH - OFF_CYC_HI);
    localparam logic [AW-1:0] A_ST = AW'(DM_DEPTH - OFF_STCNT);
    localparam logic [AW-1:0] A_TH = AW'(DM_DEPTH - OFF_TOHOST);

    logic [63:0] cycle_q, cycle_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] stcnt_q, stcnt_d;
    logic [31:0] tohost_q, tohost_d;
    logic        done_q, done_d;
    logic [31:0] code_q, code_d;
    logic [31:0] th_new;
    logic        sel_lo, sel_hi, sel_st, sel_th, wr;

    assign sel_lo = (addr_i == A_LO);
    assign sel_hi = (addr_i == A_HI);
    assign sel_st = (addr_i == A_ST);
    assign sel_th = (addr_i == A_TH);
    assign hit_o  = sel_lo | sel_hi | sel_st | sel_th;
    assign wr     = ready_i && (web_i != WEB_NONE);
    assign th_new = merge_bytes(tohost_q, di_i, web_i);

    always_comb begin
        cycle_d  = cycle_q;
        shadow_d = shadow_q;
        stcnt_d  = stcnt_q;
        tohost_d = tohost_q;
        done_d   = done_q;
        code_d   = code_q;
        if (ready_i) cycle_d = cycle_q + 64'd1;
        // Reading lo freezes hi so a lo-then-hi pair is atomic
        if (ready_i && oe_i && sel_lo) shadow_d = cycle_q[63:32];
        if (ram_we_i) stcnt_d = stcnt_q + 32'd1;
        if (wr && sel_th) begin
            tohost_d = th_new;
            if (th_new != '0) begin
                done_d = 1'b1;
                code_d = th_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q  <= '0;
            shadow_q <= '0;
            stcnt_q  <= '0;
            tohost_q <= '0;
            done_q   <= 1'b0;
            code_q   <= '0;
        end else begin
            cycle_q  <= cycle_d;
            shadow_q <= shadow_d;
            stcnt_q  <= stcnt_d;
            tohost_q <= tohost_d;
            done_q   <= done_d;
            code_q   <= code_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        unique case (1'b1)
            sel_lo:  rdata_o = cycle_q[31:0];
            sel_hi:  rdata_o = shadow_q;
            sel_st:  rdata_o = stcnt_q;
            sel_th:  rdata_o = tohost_q;
            default: rdata_o = '0;
        endcase
    end

    assign done_o      = done_q;
    assign done_code_o = code_q;
endmodule

// File: rtl/dm_sram_responder.sv
// Data SRAM responder with post-reset self-clear.
// Define DM_MMIO_EN to map the counter/tohost window into the top words.
module dm_sram_responder
    import dm_pkg::*;
#(
    parameter int DM_DEPTH   = 16384,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    dm_sram_responder_if.slave   dm,
    output logic                 ready_o,
    output logic                 done_o,
    output logic [31:0]          done_code_o
);
    localparam int AW = $clog2(DM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DM_DEPTH];
    dm_state_e             state_q, state_d;
    logic [AW-1:0]         clr_idx_q, clr_idx_d;
    logic                  rdy;
    logic                  ram_we;
    logic                  mmio_hit;
    logic [31:0]           mmio_rdata;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(DM_DEPTH - 1)) begin
                state_d   = READY;
                clr_idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign rdy     = (state_q == READY);
    assign ready_o = rdy;
    assign ram_we  = rdy && (dm.DM_WEB != WEB_NONE) && !mmio_hit;

    // Array has no reset; the clear FSM owns its contents after reset
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we && !dm.DM_WEB[i]) begin
                    mem_q[dm.DM_A][8*i +: 8] <= dm.DM_DI[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        dm.DM_DO = '0;
        if (rdy && dm.DM_OE) begin
            dm.DM_DO = mmio_hit ? mmio_rdata : mem_q[dm.DM_A];
        end
    end

`ifdef DM_MMIO_EN
    dm_mmio_regs #(
        .DM_DEPTH (DM_DEPTH)
    ) u_mmio (
        .clk         (clk),
        .rst         (rst),
        .ready_i     (rdy),
        .oe_i        (dm.DM_OE),
        .addr_i      (dm.DM_A),
        .web_i       (dm.DM_WEB),
        .di_i        (dm.DM_DI),
        .ram_we_i    (ram_we),
        .hit_o       (mmio_hit),
        .rdata_o     (mmio_rdata),
        .done_o      (done_o),
        .done_code_o (done_code_o)
    );
`else
    assign mmio_hit    = 1'b0;
    assign mmio_rdata  = '0;
    assign done_o      = 1'b0;
    assign done_code_o = '0;
`endif
endmodule

// File: doc/dm_sram_responder.md
# dm_sram_responder

Data-memory responder on the target side of the CPU data-memory port. It holds the data SRAM array and answers the CPU's zero-wait-state requests: a combinational read, and a byte-masked write committed at the clock edge. After reset it runs a self-clear sequence over the array before accepting stores. Optionally it maps a small register window (cycle counter, store counter, tohost) into the top of the address space for simulation and benchmark control.

## Interface
Parameters:
- DM_DEPTH, 16384: words in the array; word address width is $clog2(DM_DEPTH).
- DATA_WIDTH, 32: word width; must be 32 (4 byte lanes).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- DM_OE  input  1  read enable from the CPU.
- DM_A  input  $clog2(DM_DEPTH)  word address.
- DM_WEB  input  4  per-byte write enable, active-low; bit i controls DI[8i+7:8i].
- DM_DI  input  32  write data, already lane-aligned by the CPU.
- DM_DO  output  32  read data, combinational.
- ready_o  output  1  high once the clear sequence is done; the top level holds the CPU in reset while it is low.
- done_o  output  1  sticky; set by a nonzero tohost write (MMIO only, otherwise tied to 0).
- done_code_o  output  32  last value written to tohost (MMIO only, otherwise 0).

## Operation
- FSM states: CLEAR and READY.
  - Reset sends the FSM to CLEAR with clr_idx=0.
  - In CLEAR, word clr_idx is written with 0 each cycle and clr_idx increments.
  - When clr_idx==DM_DEPTH-1 is written, the FSM moves to READY and stays there until the next reset.
- In CLEAR:
  - CPU writes are ignored.
  - DM_DO=0.
  - ready_o=0.
- Read:
  - DM_DO = mem[DM_A] when DM_OE=1 and state is READY.
  - DM_DO=0 when DM_OE=0.
- Write: in READY, each lane i with DM_WEB[i]=0 updates mem[DM_A] byte i at the edge. DM_WEB=4'hF is no write.
- Read and write to the same address in the same cycle: DM_DO returns the pre-write contents. The new data is visible the following cycle.
- Out-of-range addresses do not occur: the address width exactly covers DM_DEPTH.

## Timing
- Read latency is 0 cycles (combinational from DM_OE, DM_A and the array).
- Write commits at the first rising edge with DM_WEB≠4'hF.
- Clear takes exactly DM_DEPTH cycles after rst deasserts. ready_o rises in the cycle after the last clear write.
- Reset values:
  - DM_DO=0, ready_o=0, done_o=0, done_code_o=0.
  - MMIO counters and registers = 0.
  - Array contents are not reset asynchronously; they are cleared by the FSM.
- Reset asserted mid-clear or mid-run: immediate return to CLEAR with clr_idx=0, and the full clear restarts.

## Configuration
- Macro DM_MMIO_EN.
- Defined: the top 4 words are registers, not RAM.
  - DM_DEPTH-4: cycle_lo (read-only).
    - A read with DM_OE=1 latches cycle[63:32] into a shadow register.
  - DM_DEPTH-3: cycle_hi (read-only).
    - Returns the shadow, giving an atomic 64-bit read when lo is read first.
  - DM_DEPTH-2: store_cnt (read-only).
    - Increments once per RAM write cycle; wraps 2^32-1→0.
  - DM_DEPTH-1: tohost (read/write, byte-masked).
    - If the post-write value is nonzero, done_o sets and done_code_o takes that value.
  - cycle is 64-bit, increments every READY cycle and wraps to 0. It counts from the first READY cycle.
  - Writes to read-only registers are ignored and do not increment store_cnt.
- Undefined: all DM_DEPTH words are RAM, no counters exist, and done_o/done_code_o are tied to 0.

## Structure
- Package dm_pkg contains:
  - FSM state enum {CLEAR, READY}.
  - MMIO word offsets (OFF_CYC_LO=4, OFF_CYC_HI=3, OFF_STCNT=2, OFF_TOHOST=1, counted down from DM_DEPTH).
  - Constant WEB_NONE=4'hF.
- Sub-module dm_mmio_regs holds the counters, shadow register, tohost, decode and read mux. It is instantiated only under DM_MMIO_EN.
- The top level holds the array, the clear FSM and the RAM/MMIO read mux.

## Test plan
- Reset, DM_DEPTH=64:
  - ready_o stays 0 for 64 cycles, then goes 1.
  - Every word then reads 0.
- Byte write: write 0xAABBCCDD to addr 5 with DM_WEB=0, then DM_WEB=4'b1101 with DI=0x00001100. Addr 5 must read 0xAABB11DD.
- Same-cycle read/write to addr 7 (old value 0x1, new 0x2): DM_DO=0x1 in that cycle and 0x2 in the next.
- Reset asserted at clear cycle 20: after deassertion ready_o stays low for a full 64 cycles, and CPU writes during clear have no effect.
- MMIO (DM_MMIO_EN):
  - 3 RAM stores make store_cnt read 3.
  - Force cycle to 0xFFFFFFFF; reading lo then hi returns lo=0xFFFFFFFF, hi=0 (shadow), and the next lo read returns 1.
- MMIO tohost: a write of 0 leaves done_o=0. A write of 0x1 sets done_o=1 and done_code_o=1, and done_o stays 1 after a later write of 0.
